// File: rtl/rng_share_if.sv
// Request/grant bundle between the random-number consumers and rng_share_arbiter.
// Signal names keep the arbiter's point of view: *_i flows into it, *_o out of it.
interface rng_share_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req_i;
  logic             seed_load_i;
  logic [15:0]      seed_i;
  logic [N_REQ-1:0] ack_o;
  logic [15:0]      data_o;
  logic [ID_W-1:0]  id_o;
  logic             busy_o;

  modport master (
    output req_i, seed_load_i, seed_i,
    input  ack_o, data_o, id_o, busy_o
  );

  modport slave (
    input  req_i, seed_load_i, seed_i,
    output ack_o, data_o, id_o, busy_o
  );
endinterface

// File: rtl/rng_share_arbiter.sv
// One 16-bit Fibonacci LFSR shared round-robin between N_REQ requesters; every
// grant returns s % (O_MAX-O_MIN+1) + O_MIN of the pre-advance state and steps it once.
module rng_share_arbiter #(
  parameter logic [15:0] SEED   = 16'h0005,
  parameter int          O_MAX  = 1024,
  parameter int          O_MIN  = 1,
  parameter int          N_REQ  = 4,
  parameter int          WARMUP = 16
) (
  input  logic       clk,
  input  logic       rst,
  rng_share_if.slave bus
);
  localparam int          ID_W      = $clog2(N_REQ);
  // 17 bits so the full 0..65535 range (span 65536) still fits.
  localparam logic [16:0] SPAN      = 17'(O_MAX - O_MIN + 1);
  localparam logic [7:0]  WARM_LAST = 8'(WARMUP);

  typedef enum logic {WARM, RUN} state_e;

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d, lfsr_next, map_val;
  logic [7:0]       warm_cnt_q, warm_cnt_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d, id_q, id_d, win_idx, cand;
  logic [N_REQ-1:0] ack_q, ack_d, eligible;
  logic [15:0]      data_q, data_d;
  logic             busy_q, found;

  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign map_val   = 16'(({1'b0, lfsr_q} % SPAN) + 17'(O_MIN));

  // A requester acked this cycle is masked so a held request is not served twice in a row.
  assign eligible = bus.req_i & ~ack_q;

  // NOTE: every variable written in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = rr_ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (cand == ID_W'(N_REQ - 1)) ? '0 : cand + ID_W'(1);
      if (!found && eligible[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    warm_cnt_d = warm_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    ack_d      = '0;
    data_d     = data_q;
    id_d       = id_q;

    if (bus.seed_load_i) begin
      lfsr_d     = (bus.seed_i == 16'h0000) ? SEED : bus.seed_i;
      warm_cnt_d = '0;
      state_d    = WARM;
    end else begin
      case (state_q)
        WARM: begin
          if (warm_cnt_q == WARM_LAST) begin
            state_d = RUN;
          end else begin
            lfsr_d     = lfsr_next;
            warm_cnt_d = warm_cnt_q + 8'd1;
          end
        end
        RUN: begin
          if (found) begin
            ack_d    = N_REQ'(1) << win_idx;
            data_d   = map_val;
            id_d     = win_idx;
            lfsr_d   = lfsr_next;
            rr_ptr_d = win_idx;
          end
        end
        default: state_d = WARM;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WARM;
      lfsr_q     <= SEED;
      warm_cnt_q <= '0;
      rr_ptr_q   <= ID_W'(N_REQ - 1);
      ack_q      <= '0;
      data_q     <= '0;
      id_q       <= '0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      warm_cnt_q <= warm_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
      id_q       <= id_d;
      busy_q     <= (state_d == WARM);
    end
  end

  assign bus.ack_o  = ack_q;
  assign bus.data_o = data_q;
  assign bus.id_o   = id_q;
  assign bus.busy_o = busy_q;
endmodule

// File: tb/tb_rng_share_arbiter.sv
// Bench for rng_share_arbiter: directed vector table on a WARMUP=0 instance, a warm-up
// sequence on a WARMUP=16 instance, and random traffic against a behavioural model.
module tb_rng_share_arbiter;
  localparam int          N      = 4;
  localparam int          O_MAX  = 1024;
  localparam int          O_MIN  = 1;
  localparam logic [15:0] SEED   = 16'h0005;
  localparam int          W0     = 0;
  localparam int          W16    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rng_share_if #(.N_REQ(N)) bus0 ();
  rng_share_if #(.N_REQ(N)) bus16 ();

  rng_share_arbiter #(.SEED(SEED), .O_MAX(O_MAX), .O_MIN(O_MIN), .N_REQ(N), .WARMUP(W0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  rng_share_arbiter #(.SEED(SEED), .O_MAX(O_MAX), .O_MIN(O_MIN), .N_REQ(N), .WARMUP(W16))
    dut16 (.clk(clk), .rst(rst), .bus(bus16));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference arithmetic straight from the rules: shift left, feed back the tap parity.
  function automatic int unsigned ref_step(input int unsigned s);
    int unsigned fb;
    fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
    return ((s << 1) | fb) & 32'hFFFF;
  endfunction

  function automatic logic [15:0] ref_map(input int unsigned s);
    return 16'((s % (O_MAX - O_MIN + 1)) + O_MIN);
  endfunction

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        sl;
    logic [15:0] seed;
    logic [3:0]  ack;
    logic [15:0] data;
    logic [1:0]  id;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] req, input logic sl, input logic [15:0] seed,
                     input logic [3:0] ack, input logic [15:0] data, input logic [1:0] id,
                     input logic busy);
    vec_t v;
    v.rst = r; v.req = req; v.sl = sl; v.seed = seed;
    v.ack = ack; v.data = data; v.id = id; v.busy = busy;
    vecs.push_back(v);
  endtask

  task automatic add_single_req_run();
    add(0, 4'b0001, 0, 0, 4'b0000,  0, 0, 0);
    add(0, 4'b0001, 0, 0, 4'b0001,  6, 0, 0);
    add(0, 4'b0001, 0, 0, 4'b0000,  6, 0, 0);
    add(0, 4'b0001, 0, 0, 4'b0001, 11, 0, 0);
    add(0, 4'b0001, 0, 0, 4'b0000, 11, 0, 0);
    add(0, 4'b0001, 0, 0, 4'b0001, 21, 0, 0);
  endtask

  // Behavioural model: counts remaining busy cycles and remembers the last winner.
  int unsigned m_lfsr;
  int          m_warm_left, m_ptr, m_last_win, m_id;
  logic [15:0] m_data;
  logic        m_busy;
  logic [3:0]  m_ack;

  task automatic model_reset(input int warmup);
    m_lfsr = SEED; m_warm_left = warmup + 1; m_ptr = N - 1; m_last_win = -1;
    m_id = 0; m_data = 0; m_busy = 1; m_ack = 0;
  endtask

  task automatic model_cycle(input int warmup, input logic [3:0] req, input logic sl,
                             input logic [15:0] seed);
    int win, c;
    win = -1;
    if (sl) begin
      m_lfsr = (seed == 0) ? SEED : seed;
      m_warm_left = warmup + 1;
      m_busy = 1;
    end else if (m_warm_left > 0) begin
      if (m_warm_left > 1) m_lfsr = ref_step(m_lfsr);
      m_warm_left--;
      m_busy = (m_warm_left != 0);
    end else begin
      for (int k = 1; k <= N; k++) begin
        c = (m_ptr + k) % N;
        if (win < 0 && req[c] && c != m_last_win) win = c;
      end
      if (win >= 0) begin
        m_data = ref_map(m_lfsr);
        m_id   = win;
        m_lfsr = ref_step(m_lfsr);
        m_ptr  = win;
      end
      m_busy = 0;
    end
    m_last_win = win;
    m_ack = (win >= 0) ? 4'(1 << win) : 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt, got;
    int unsigned s;

    bus0.req_i = 0;  bus0.seed_load_i = 0;  bus0.seed_i = 0;
    bus16.req_i = 0; bus16.seed_load_i = 0; bus16.seed_i = 0;

    // ---------------- directed table on WARMUP=0 ----------------
    add(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 1);
    add_single_req_run();
    add(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 1);
    add(0, 4'b0000, 0, 0, 4'b0000,  0, 0, 0);
    add(0, 4'b1111, 0, 0, 4'b0001,  6, 0, 0);
    add(0, 4'b1111, 0, 0, 4'b0010, 11, 1, 0);
    add(0, 4'b1111, 0, 0, 4'b0100, 21, 2, 0);
    add(0, 4'b1111, 0, 0, 4'b1000, 41, 3, 0);
    add(0, 4'b1111, 0, 0, 4'b0001, 81, 0, 0);
    add(1, 4'b1111, 0, 0, 4'b0000,  0, 0, 1);   // reset drops the in-flight grant
    add_single_req_run();
    add(0, 4'b0000, 1, 16'h1234, 4'b0000,  21, 0, 1);
    add(0, 4'b0000, 0, 0,        4'b0000,  21, 0, 0);
    add(0, 4'b0001, 0, 0,        4'b0001, 565, 0, 0);
    add(0, 4'b0010, 1, 16'h0000, 4'b0000, 565, 0, 1);
    add(0, 4'b0010, 0, 0,        4'b0000, 565, 0, 0);
    add(0, 4'b0010, 0, 0,        4'b0010,   6, 1, 0);
    add(0, 4'b0010, 0, 0,        4'b0000,   6, 1, 0);
    add(0, 4'b0010, 0, 0,        4'b0010,  11, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      bus0.req_i = vecs[i].req;
      bus0.seed_load_i = vecs[i].sl;
      bus0.seed_i = vecs[i].seed;
      @(posedge clk); #1;
      check($sformatf("vec%0d.ack",  i), 32'(bus0.ack_o),  32'(vecs[i].ack));
      check($sformatf("vec%0d.data", i), 32'(bus0.data_o), 32'(vecs[i].data));
      check($sformatf("vec%0d.id",   i), 32'(bus0.id_o),   32'(vecs[i].id));
      check($sformatf("vec%0d.busy", i), 32'(bus0.busy_o), 32'(vecs[i].busy));
    end
    rst = 0; bus0.req_i = 0; bus0.seed_load_i = 0; bus0.seed_i = 0;

    // ---------------- WARMUP=16: busy length and first value ----------------
    bus16.req_i = 4'b0001;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    busy_cnt = bus16.busy_o ? 1 : 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (bus16.busy_o) busy_cnt++;
      else break;
    end
    check("warm16.busy_cycles", 32'(busy_cnt), 32'd17);
    got = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus16.ack_o != 0) begin
        got = 1;
        break;
      end
    end
    s = SEED;
    repeat (W16) s = ref_step(s);
    check("warm16.first_grant_seen", 32'(got), 32'd1);
    check("warm16.first_data", 32'(bus16.data_o), 32'(ref_map(s)));
    check("warm16.first_ack", 32'(bus16.ack_o), 32'b0001);
    bus16.req_i = 0;

    // ---------------- random traffic vs model on WARMUP=0 ----------------
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset(W0);
    for (int i = 0; i < 600; i++) begin
      bus0.req_i = 4'($urandom);
      bus0.seed_load_i = ($urandom_range(0, 23) == 0);
      bus0.seed_i = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      model_cycle(W0, bus0.req_i, bus0.seed_load_i, bus0.seed_i);
      @(posedge clk); #1;
      check($sformatf("rnd%0d.ack",  i), 32'(bus0.ack_o),  32'(m_ack));
      check($sformatf("rnd%0d.data", i), 32'(bus0.data_o), 32'(m_data));
      check($sformatf("rnd%0d.id",   i), 32'(bus0.id_o),   32'(m_id));
      check($sformatf("rnd%0d.busy", i), 32'(bus0.busy_o), 32'(m_busy));
    end
    bus0.req_i = 0; bus0.seed_load_i = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
